mem_stage_pipe: RTL and testbench

Pipelined, handshaked memory-access stage for the MIPS core. It sits between EX and WB and takes one instruction per accepted beat. It performs byte, halfword and word loads and stores over a req/ack data bus that has variable wait states, and selects the register writeback value. Misaligned accesses and (optionally) bus timeouts are reported as exceptions instead of silently corrupting data.

---
 rtl/mem_stage_pkg.sv | 32 +++
 rtl/mem_lane_align.sv | 42 ++++
 rtl/mem_stage_pipe.sv | 199 +++++++++++++++++++
 tb/tb_mem_stage_pipe.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared codes, state enum and writeback select for mem_stage_pipe
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_LOAD = 2'b01;
    localparam logic [1:0] M2R_PC   = 2'b10;
    localparam logic [1:0] M2R_ZERO = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_BUS
    } state_t;

    function automatic logic [31:0] wb_select(
        input logic [1:0]  m2r,
        input logic [31:0] alu,
        input logic [31:0] load,
        input logic [31:0] pc
    );
        case (m2r)
            M2R_ALU:  return alu;
            M2R_LOAD: return load;
            M2R_PC:   return pc;
            default:  return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering: store replication, byte enables, load extract, misalign
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata >> {lane, 3'b000};
        be        = 4'b1111;
        wdata     = store_data;
        load_data = shifted;
        misalign  = 1'b0;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << lane;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be        = 4'b0011 << lane;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
                misalign  = lane[0];
            end
            default: begin
                misalign  = (lane != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_pipe.sv
// rtl/mem_stage_pipe.sv - MIPS MEM stage with req/ack bus; optional bus timeout under MEM_TIMEOUT_EN
module mem_stage_pipe
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int REG_AW         = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       store_data,
    input  logic [1:0]        mem_to_reg,
    input  logic [31:0]       new_pc,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              reg_wr_in,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       wb_data,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_en,
    output logic              exc_misalign,
    output logic              exc_bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_stage_pipe: TIMEOUT_CYCLES must be at least 1");
    end

    state_t state, state_nx;

    // Beat fields held for the duration of a bus transaction
    logic [1:0]        cap_lane;
    logic [1:0]        cap_size;
    logic              cap_signed;
    logic              cap_store;
    logic [1:0]        cap_m2r;
    logic [31:0]       cap_alu;
    logic [31:0]       cap_pc;
    logic [REG_AW-1:0] cap_rd;
    logic              cap_reg_wr;

    logic        in_bus;
    logic        accept;
    logic        is_mem;
    logic        bus_done;
    logic        timeout_hit;
    logic [1:0]  al_lane;
    logic [1:0]  al_size;
    logic        al_signed;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_misalign;

    assign in_bus   = (state == ST_BUS);
    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mem   = mem_rd || mem_wr;
    assign bus_done = in_bus && (bus_ack || timeout_hit);

    // The aligner serves the incoming beat in IDLE and the captured beat in BUS
    assign al_lane   = in_bus ? cap_lane   : alu_out[1:0];
    assign al_size   = in_bus ? cap_size   : mem_size;
    assign al_signed = in_bus ? cap_signed : mem_signed;

    mem_lane_align u_align (
        .lane       (al_lane),
        .size       (al_size),
        .sign_ext   (al_signed),
        .store_data (store_data),
        .rdata      (bus_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misalign   (al_misalign)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    assign timeout_hit = in_bus && !bus_ack && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (!in_bus) begin
            tmo_cnt <= '0;
        end else if (!bus_ack) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign exc_bus     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept && is_mem && !al_misalign) state_nx = ST_BUS;
            ST_BUS:  if (bus_done) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_be       <= '0;
            out_valid    <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_en        <= 1'b0;
            exc_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            exc_bus      <= 1'b0;
`endif
            cap_lane     <= '0;
            cap_size     <= '0;
            cap_signed   <= 1'b0;
            cap_store    <= 1'b0;
            cap_m2r      <= '0;
            cap_alu      <= '0;
            cap_pc       <= '0;
            cap_rd       <= '0;
            cap_reg_wr   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (is_mem && !al_misalign) begin
                    cap_lane   <= alu_out[1:0];
                    cap_size   <= mem_size;
                    cap_signed <= mem_signed;
                    cap_store  <= mem_wr && !mem_rd;
                    cap_m2r    <= mem_to_reg;
                    cap_alu    <= alu_out;
                    cap_pc     <= new_pc;
                    cap_rd     <= rd_in;
                    cap_reg_wr <= reg_wr_in;
                    bus_req    <= 1'b1;
                    bus_we     <= mem_wr && !mem_rd;
                    bus_addr   <= {alu_out[ADDR_W-1:2], 2'b00};
                    bus_be     <= al_be;
                    bus_wdata  <= al_wdata;
                end else begin
                    // Non-memory op or misaligned access retires straight from IDLE
                    out_valid    <= 1'b1;
                    wb_data      <= wb_select(mem_to_reg, alu_out, al_load, new_pc);
                    wb_rd        <= rd_in;
                    wb_en        <= reg_wr_in && !is_mem;
                    exc_misalign <= is_mem;
`ifdef MEM_TIMEOUT_EN
                    exc_bus      <= 1'b0;
`endif
                end
            end else if (bus_done) begin
                out_valid    <= 1'b1;
                wb_data      <= wb_select(cap_m2r, cap_alu, al_load, cap_pc);
                wb_rd        <= cap_rd;
                wb_en        <= bus_ack && cap_reg_wr && !cap_store;
                exc_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                exc_bus      <= !bus_ack;
`endif
                bus_req      <= 1'b0;
                bus_we       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb/tb_mem_stage_pipe.sv - directed scoreboard bench for mem_stage_pipe
module tb_mem_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic [1:0]  mem_to_reg;
    logic [31:0] new_pc;
    logic [4:0]  rd_in;
    logic        reg_wr_in;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_en;
    logic        exc_misalign;
    logic        exc_bus;

    always #5 clk = ~clk;

    mem_stage_pipe #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (4),
        .REG_AW         (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_signed   (mem_signed),
        .alu_out      (alu_out),
        .store_data   (store_data),
        .mem_to_reg   (mem_to_reg),
        .new_pc       (new_pc),
        .rd_in        (rd_in),
        .reg_wr_in    (reg_wr_in),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_be       (bus_be),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_en        (wb_en),
        .exc_misalign (exc_misalign),
        .exc_bus      (exc_bus)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [1:0]  m2r;
        logic [31:0] pc;
        logic [4:0]  rdi;
        logic        rw;
    } beat_t;

    typedef struct {
        logic        dc;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        en;
        logic        mis;
        logic        ebus;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   acc_cyc = 0;
    int   errors  = 0;
    int   checks  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic beat_t mk(input logic rd, input logic wr, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] alu, input logic [31:0] sd,
                                 input logic [1:0] m2r, input logic [31:0] pc,
                                 input logic [4:0] rdi, input logic rw);
        beat_t b;
        b.rd = rd; b.wr = wr; b.size = size; b.sgn = sgn; b.alu = alu;
        b.sd = sd; b.m2r = m2r; b.pc = pc; b.rdi = rdi; b.rw = rw;
        return b;
    endfunction

    function automatic exp_t ex(input logic dc, input logic [31:0] data, input logic [4:0] rd,
                                input logic en, input logic mis, input logic ebus);
        exp_t e;
        e.dc = dc; e.data = data; e.rd = rd; e.en = en; e.mis = mis; e.ebus = ebus;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_beat(input beat_t b);
        mem_rd     = b.rd;
        mem_wr     = b.wr;
        mem_size   = b.size;
        mem_signed = b.sgn;
        alu_out    = b.alu;
        store_data = b.sd;
        mem_to_reg = b.m2r;
        new_pc     = b.pc;
        rd_in      = b.rdi;
        reg_wr_in  = b.rw;
    endtask

    // Returns at the negedge following the accepting edge
    task automatic send(input string tag, input beat_t b);
        int n = 0;
        set_beat(b);
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk1({tag, ".in_ready"}, in_ready, 1'b1);
        acc_cyc = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic get_out(input string tag, input int e_lat);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk1({tag, ".valid"}, out_valid, 1'b1);
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s.sb: observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dc) begin
                chk({tag, ".data"}, wb_data, e.data);
                chk({tag, ".rd"}, {27'b0, wb_rd}, {27'b0, e.rd});
            end
            chk1({tag, ".wb_en"}, wb_en, e.en);
            chk1({tag, ".exc_mis"}, exc_misalign, e.mis);
            chk1({tag, ".exc_bus"}, exc_bus, e.ebus);
            if (e_lat >= 0) chk({tag, ".latency"}, 32'(cyc - acc_cyc), 32'(e_lat));
        end
    endtask

    // waits < 0 means the bus never acknowledges
    task automatic mem_op(input string tag, input beat_t b, input int waits,
                          input logic [31:0] rdata, input logic [31:0] e_addr,
                          input logic e_we, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input int e_lat);
        send(tag, b);
        chk1({tag, ".req"}, bus_req, 1'b1);
        chk({tag, ".addr"}, bus_addr, e_addr);
        chk1({tag, ".we"}, bus_we, e_we);
        chk({tag, ".be"}, {28'b0, bus_be}, {28'b0, e_be});
        chk({tag, ".wdata"}, bus_wdata, e_wdata);
        for (int i = 0; i < waits; i++) tick();
        if (waits >= 0) begin
            chk1({tag, ".req_hold"}, bus_req, 1'b1);
            chk({tag, ".addr_hold"}, bus_addr, e_addr);
            bus_ack   = 1'b1;
            bus_rdata = rdata;
            tick();
            bus_ack   = 1'b0;
            bus_rdata = 32'h0;
        end
        get_out(tag, e_lat);
        chk1({tag, ".req_fall"}, bus_req, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        out_ready = 1'b1;
        set_beat(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0, 5'd0, 1'b0));
        @(negedge clk);
        tick();
        tick();

        chk1("rst.out_valid", out_valid, 1'b0);
        chk1("rst.bus_req", bus_req, 1'b0);
        chk1("rst.bus_we", bus_we, 1'b0);
        chk({"rst.bus_be"}, {28'b0, bus_be}, 32'h0);
        chk("rst.bus_addr", bus_addr, 32'h0);
        chk("rst.bus_wdata", bus_wdata, 32'h0);
        chk("rst.wb_data", wb_data, 32'h0);
        chk("rst.wb_rd", {27'b0, wb_rd}, 32'h0);
        chk1("rst.wb_en", wb_en, 1'b0);
        chk1("rst.exc_mis", exc_misalign, 1'b0);
        chk1("rst.exc_bus", exc_bus, 1'b0);
        reset = 1'b1;
        tick();

        sb.push_back(ex(1'b1, 32'h1234, 5'd3, 1'b1, 1'b0, 1'b0));
        send("alu", mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0, 2'b00, 32'h0, 5'd3, 1'b1));
        chk1("alu.no_req", bus_req, 1'b0);
        get_out("alu", 1);
        tick();
        chk1("alu.drained", out_valid, 1'b0);

        sb.push_back(ex(1'b1, 32'h0000_0400, 5'd4, 1'b1, 1'b0, 1'b0));
        sb.push_back(ex(1'b1, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0));
        set_beat(mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h5555, 32'h0, 2'b10, 32'h400, 5'd4, 1'b1));
        in_valid = 1'b1;
        acc_cyc  = cyc;
        tick();
        get_out("b2b_pc", 1);
        chk1("b2b.in_ready", in_ready, 1'b1);
        set_beat(mk(1'b0, 1'b0, 2'b10, 1'b0, 32'hFFFF, 32'h0, 2'b11, 32'h800, 5'd5, 1'b1));
        acc_cyc = cyc;
        tick();
        get_out("b2b_zero", 1);
        in_valid = 1'b0;

        sb.push_back(ex(1'b1, 32'hFFFF_FF80, 5'd6, 1'b1, 1'b0, 1'b0));
        mem_op("lb", mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2'b01, 32'h0, 5'd6, 1'b1),
               3, 32'h80FF_0000, 32'h10, 1'b0, 4'b1000, 32'h0, 5);
        sb.push_back(ex(1'b1, 32'h0000_0080, 5'd7, 1'b1, 1'b0, 1'b0));
        mem_op("lbu", mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2'b01, 32'h0, 5'd7, 1'b1),
               0, 32'h80FF_0000, 32'h10, 1'b0, 4'b1000, 32'h0, 2);
        sb.push_back(ex(1'b1, 32'hFFFF_8001, 5'd8, 1'b1, 1'b0, 1'b0));
        mem_op("lh", mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 2'b01, 32'h0, 5'd8, 1'b1),
               1, 32'h8001_1234, 32'h0, 1'b0, 4'b1100, 32'h0, 3);
        sb.push_back(ex(1'b1, 32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0, 1'b0));
        mem_op("lw", mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 2'b01, 32'h0, 5'd9, 1'b1),
               2, 32'hDEAD_BEEF, 32'h8, 1'b0, 4'b1111, 32'h0, 4);
        sb.push_back(ex(1'b1, 32'h0123_4567, 5'd10, 1'b1, 1'b0, 1'b0));
        mem_op("rdwr", mk(1'b1, 1'b1, 2'b11, 1'b0, 32'hC, 32'h0, 2'b01, 32'h0, 5'd10, 1'b1),
               0, 32'h0123_4567, 32'hC, 1'b0, 4'b1111, 32'h0, 2);

        sb.push_back(ex(1'b1, 32'h22, 5'd11, 1'b0, 1'b0, 1'b0));
        mem_op("sh", mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 2'b00, 32'h0, 5'd11, 1'b1),
               1, 32'h0, 32'h20, 1'b1, 4'b1100, 32'hBEEF_BEEF, 3);
        sb.push_back(ex(1'b1, 32'h1, 5'd12, 1'b0, 1'b0, 1'b0));
        mem_op("sb", mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h1, 32'h1234_56A5, 2'b00, 32'h0, 5'd12, 1'b1),
               0, 32'h0, 32'h0, 1'b1, 4'b0010, 32'hA5A5_A5A5, 2);
        sb.push_back(ex(1'b1, 32'h4, 5'd13, 1'b0, 1'b0, 1'b0));
        mem_op("sw", mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFE_F00D, 2'b00, 32'h0, 5'd13, 1'b1),
               0, 32'h0, 32'h4, 1'b1, 4'b1111, 32'hCAFE_F00D, 2);

        sb.push_back(ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0));
        send("lw_mis", mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 2'b01, 32'h0, 5'd14, 1'b1));
        chk1("lw_mis.no_req", bus_req, 1'b0);
        get_out("lw_mis", 1);
        tick();
        chk1("lw_mis.no_req2", bus_req, 1'b0);
        sb.push_back(ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0));
        send("lh_mis", mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h3, 32'h0, 2'b01, 32'h0, 5'd15, 1'b1));
        chk1("lh_mis.no_req", bus_req, 1'b0);
        get_out("lh_mis", 1);
        sb.push_back(ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0));
        send("sw_mis", mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h1, 32'h1111, 2'b00, 32'h0, 5'd16, 1'b1));
        chk1("sw_mis.no_req", bus_req, 1'b0);
        get_out("sw_mis", 1);
        tick();

        bus_ack   = 1'b1;
        bus_rdata = 32'h7777_7777;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        chk1("idle_ack.out_valid", out_valid, 1'b0);
        chk1("idle_ack.bus_req", bus_req, 1'b0);

        out_ready = 1'b0;
        sb.push_back(ex(1'b1, 32'hCAFE, 5'd17, 1'b1, 1'b0, 1'b0));
        send("stall", mk(1'b0, 1'b0, 2'b10, 1'b0, 32'hCAFE, 32'h0, 2'b00, 32'h0, 5'd17, 1'b1));
        set_beat(mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h9999, 32'h0, 2'b00, 32'h0, 5'd1, 1'b1));
        for (int i = 0; i < 3; i++) begin
            chk1("stall.valid_hold", out_valid, 1'b1);
            chk("stall.data_hold", wb_data, 32'hCAFE);
            chk("stall.rd_hold", {27'b0, wb_rd}, 32'd17);
            chk1("stall.in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        get_out("stall", -1);
        tick();
        chk1("stall.drained", out_valid, 1'b0);

        send("rst_bus", mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 2'b01, 32'h0, 5'd18, 1'b1));
        chk1("rst_bus.req", bus_req, 1'b1);
        reset     = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_1111;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        chk1("rst_bus.req_drop", bus_req, 1'b0);
        chk1("rst_bus.out_valid", out_valid, 1'b0);
        reset = 1'b1;
        tick();
        chk1("rst_bus.ack_discarded", out_valid, 1'b0);
        chk1("rst_bus.in_ready", in_ready, 1'b1);

`ifdef MEM_TIMEOUT_EN
        sb.push_back(ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1));
        mem_op("tmo", mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 2'b01, 32'h0, 5'd19, 1'b1),
               -1, 32'h0, 32'h50, 1'b0, 4'b1111, 32'h0, 5);
        tick();
        chk1("tmo.req_after", bus_req, 1'b0);
        sb.push_back(ex(1'b1, 32'h5A5A_5A5A, 5'd20, 1'b1, 1'b0, 1'b0));
        mem_op("tmo_ack", mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h54, 32'h0, 2'b01, 32'h0, 5'd20, 1'b1),
               3, 32'h5A5A_5A5A, 32'h54, 1'b0, 4'b1111, 32'h0, 5);
`else
        sb.push_back(ex(1'b1, 32'h5A5A_5A5A, 5'd20, 1'b1, 1'b0, 1'b0));
        mem_op("late_ack", mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h54, 32'h0, 2'b01, 32'h0, 5'd20, 1'b1),
               12, 32'h5A5A_5A5A, 32'h54, 1'b0, 4'b1111, 32'h0, 14);
`endif
        tick();
        chk("sb.empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
